interboard_rx: RTL and testbench
================================

# interboard_rx

Receive-side link layer for the two-board Request/Ack interboard link. It synchronises the partner's `Request_in`, captures four 6-bit chunks from `inter_data_in` and answers each with a 4-phase `Ack_out`. It reassembles one 24-bit packet and presents it to game control and memory handling as a one-cycle `interboard_en` pulse with decoded fields, or as an `interboard_rst` pulse. It sits directly downstream of the physical link pins and upstream of every `interboard_*` consumer.

## Interface
- `TIMEOUT_CYCLES`, default 1_000_000: idle cycles allowed mid-packet before the partial packet is discarded.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous and active-low.
- `Request_in` in 1: partner request, asynchronous to `clk`.
- `inter_data_in` in 6: partner data chunk, stable while `Request_in` is high.
- `Ack_out` out 1: acknowledge to partner.
- `interboard_en` out 1: one-cycle pulse when a non-reset packet is delivered.
- `interboard_rst` out 1: one-cycle pulse when a reset packet is delivered.
- `interboard_msg_type` out 4: decoded message type.
- `interboard_move_dir` out 1: decoded move direction.
- `interboard_block_x` out 5: decoded block column.
- `interboard_block_y` out 3: decoded block row.
- `interboard_card` out 6: decoded card id.
- `interboard_sel_len` out 3: decoded selection length.
- `rx_error` out 1: one-cycle pulse on timeout discard.

## Operation
- Packet bit order, MSB first: `{msg_type[3:0], move_dir, block_x[4:0], block_y[2:0], card[5:0], sel_len[2:0], 2'b00}`.
- Chunk k carries packet[23-6k : 18-6k], for k = 0..3.
- `Request_in` passes through a 2-flop synchroniser. The synchronised signal is `req_s`.
- States:
  - WAIT_REQ: on `req_s`=1, latch `inter_data_in` into shift register slot `chunk_cnt`, set `Ack_out`=1, go to WAIT_REL.
  - WAIT_REL: on `req_s`=0, set `Ack_out`=0.
    - If `chunk_cnt`=3, go to DELIVER.
    - Otherwise increment `chunk_cnt` and go to WAIT_REQ.
  - DELIVER (one cycle): load all field outputs from the shift register.
    - If `msg_type`==`MSG_RST`, pulse `interboard_rst`; otherwise pulse `interboard_en`.
    - Clear `chunk_cnt`, return to WAIT_REQ.
- Field outputs hold their last delivered values until the next DELIVER. They are never updated on a reset packet except `interboard_msg_type`.
- Pad bits [1:0] are ignored. A nonzero value is not an error.
- Watchdog counter:
  - Counts every cycle while in WAIT_REL, or in WAIT_REQ with `chunk_cnt`≠0.
  - Clears on every state transition and in WAIT_REQ with `chunk_cnt`=0.
  - On reaching `TIMEOUT_CYCLES`-1: set `Ack_out`=0, `chunk_cnt`=0, go to WAIT_REQ, pulse `rx_error`. Field outputs are unchanged.
- If `req_s` is still high after a timeout, it is treated as a new chunk 0.
- `req_s` held high indefinitely in WAIT_REL is covered by the watchdog. No chunk is double-captured.
- Reset (`rst`=0 at a clock edge), including mid-packet:
  - State goes to WAIT_REQ, `chunk_cnt`=0, watchdog=0, synchroniser flops=0.
  - All outputs go to 0: `Ack_out`, `interboard_en`, `interboard_rst`, `rx_error`, all field outputs.

## Timing
- `Request_in` rise at edge t is seen as `req_s`=1 at edge t+2. Data is captured and `Ack_out`=1 at edge t+3.
- `Request_in` fall at edge u gives `Ack_out`=0 at edge u+3.
- On the last chunk, DELIVER occupies the cycle after `Ack_out` falls. `interboard_en` or `interboard_rst` is high for exactly one cycle, starting edge u+4.
- Field outputs are valid in the same cycle as the pulse and remain valid after it.
- Minimum packet time from the first `Request_in` rise is about 4 × (6 + partner latency) cycles.
- At most one delivery pulse per packet. `interboard_en` and `interboard_rst` are never high together.
- `inter_data_in` is sampled only at the capture edge. The partner guarantees it is stable from before `Request_in` rises until `Ack_out` is seen high.

## Structure
- Shared package `interboard_pkg` holds:
  - `MSG_RST` = 4'd15.
  - `CHUNKS` = 4, `CHUNK_W` = 6, `PKT_W` = 24.
  - Field bit positions.
  - State enum {WAIT_REQ, WAIT_REL, DELIVER}.
- One sub-module: `sync2`, a 2-flop synchroniser with synchronous active-low reset. It is reused by the transmit side for `Ack_in`.

## Test plan
- Single packet: `msg_type`=3, `move_dir`=1, `block_x`=17, `block_y`=5, `card`=42, `sel_len`=2, pads 0, partner Ack latency 2 cycles.
  - Required: four `Ack_out` pulses, then `interboard_en` high exactly 1 cycle, 4 cycles after the last `Request_in` fall.
  - Required: the exact field values above, held afterwards.
- Reset packet with `msg_type`=15:
  - Required: `interboard_rst` 1-cycle pulse, `interboard_en` stays 0, `block_x`, `card` and the other fields keep their previous values.
- Timeout with `TIMEOUT_CYCLES`=64: send 2 chunks, then stop.
  - Required: `rx_error` pulse 64 cycles after the last transition, `Ack_out`=0, no `interboard_en`.
  - Required: a following full packet decodes correctly.
- Reset mid-packet: after chunk 2 is captured with `Ack_out`=1, drive `rst`=0 for one cycle.
  - Required: next cycle all outputs are 0.
  - Required: a new full packet with `card`=7 is delivered correctly.
- Back-to-back packets (`card`=1, then `card`=63, no gap):
  - Required: two `interboard_en` pulses with the correct cards.
- Partner holds `Request_in` high 500 cycles with `TIMEOUT_CYCLES`=1000:
  - Required: exactly one capture, `Ack_out` high throughout, no `rx_error`.

Source files
------------

// File: rtl/interboard_pkg.sv
// Shared constants, field layout and FSM encoding for the Request/Ack interboard link.
package interboard_pkg;

    localparam logic [3:0] MSG_RST = 4'd15;

    localparam int CHUNKS  = 4;
    localparam int CHUNK_W = 6;
    localparam int PKT_W   = 24;

    // Packet layout, MSB first: msg_type, move_dir, block_x, block_y, card, sel_len, 2 pad bits
    localparam int MSG_MSB  = 23;
    localparam int MSG_LSB  = 20;
    localparam int DIR_BIT  = 19;
    localparam int BX_MSB   = 18;
    localparam int BX_LSB   = 14;
    localparam int BY_MSB   = 13;
    localparam int BY_LSB   = 11;
    localparam int CARD_MSB = 10;
    localparam int CARD_LSB = 5;
    localparam int SEL_MSB  = 4;
    localparam int SEL_LSB  = 2;

    typedef enum logic [1:0] {
        WAIT_REQ,
        WAIT_REL,
        DELIVER
    } rx_state_e;

endpackage

// File: rtl/interboard_rx_sync2.sv
// Two-flop synchroniser for a single asynchronous level; shared with the transmit side.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/interboard_rx.sv
// Receive link layer: 4-phase handshake per 6-bit chunk, reassembles a 24-bit packet
// and emits a one-cycle delivery pulse with registered, held field outputs.
module interboard_rx
    import interboard_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Request_in,
    input  logic [5:0]   inter_data_in,
    output logic         Ack_out,
    output logic         interboard_en,
    output logic         interboard_rst,
    output logic [3:0]   interboard_msg_type,
    output logic         interboard_move_dir,
    output logic [4:0]   interboard_block_x,
    output logic [2:0]   interboard_block_y,
    output logic [5:0]   interboard_card,
    output logic [2:0]   interboard_sel_len,
    output logic         rx_error
);

    localparam int CNT_W = $clog2(CHUNKS);

    logic             req_s;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      wdog_q, wdog_d;
    logic [PKT_W-1:0] shreg_q, shreg_d;
    logic             timeout;
    logic             wdog_hit;

    logic       ack_q, ack_d;
    logic       en_q, en_d;
    logic       rstp_q, rstp_d;
    logic       err_q, err_d;
    logic [3:0] msg_q, msg_d;
    logic       dir_q, dir_d;
    logic [4:0] bx_q, bx_d;
    logic [2:0] by_q, by_d;
    logic [5:0] card_q, card_d;
    logic [2:0] sel_q, sel_d;

    sync2 u_req_sync (
        .clk (clk),
        .rst (rst),
        .d_i (Request_in),
        .q_o (req_s)
    );

    assign wdog_hit = (wdog_q == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= WAIT_REQ;
            cnt_q   <= '0;
            wdog_q  <= '0;
            shreg_q <= '0;
            ack_q   <= 1'b0;
            en_q    <= 1'b0;
            rstp_q  <= 1'b0;
            err_q   <= 1'b0;
            msg_q   <= '0;
            dir_q   <= 1'b0;
            bx_q    <= '0;
            by_q    <= '0;
            card_q  <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wdog_q  <= wdog_d;
            shreg_q <= shreg_d;
            ack_q   <= ack_d;
            en_q    <= en_d;
            rstp_q  <= rstp_d;
            err_q   <= err_d;
            msg_q   <= msg_d;
            dir_q   <= dir_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            card_q  <= card_d;
            sel_q   <= sel_d;
        end
    end

    // Chunks shift in from the bottom, so after four captures chunk 0 sits in the top bits.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wdog_d  = wdog_q;
        shreg_d = shreg_q;
        timeout = 1'b0;
        case (state_q)
            WAIT_REQ: begin
                if (req_s) begin
                    shreg_d = {shreg_q[PKT_W-CHUNK_W-1:0], inter_data_in};
                    state_d = WAIT_REL;
                    wdog_d  = '0;
                end else if (cnt_q == '0) begin
                    wdog_d = '0;
                end else if (wdog_hit) begin
                    timeout = 1'b1;
                    cnt_d   = '0;
                    wdog_d  = '0;
                end else begin
                    wdog_d = wdog_q + 32'd1;
                end
            end
            WAIT_REL: begin
                if (!req_s) begin
                    wdog_d = '0;
                    if (cnt_q == CNT_W'(CHUNKS - 1)) begin
                        state_d = DELIVER;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = WAIT_REQ;
                    end
                end else if (wdog_hit) begin
                    timeout = 1'b1;
                    cnt_d   = '0;
                    wdog_d  = '0;
                    state_d = WAIT_REQ;
                end else begin
                    wdog_d = wdog_q + 32'd1;
                end
            end
            DELIVER: begin
                cnt_d   = '0;
                wdog_d  = '0;
                state_d = WAIT_REQ;
            end
            default: begin
                cnt_d   = '0;
                wdog_d  = '0;
                state_d = WAIT_REQ;
            end
        endcase
    end

    always_comb begin
        ack_d  = ack_q;
        en_d   = 1'b0;
        rstp_d = 1'b0;
        err_d  = 1'b0;
        msg_d  = msg_q;
        dir_d  = dir_q;
        bx_d   = bx_q;
        by_d   = by_q;
        card_d = card_q;
        sel_d  = sel_q;
        case (state_q)
            WAIT_REQ: begin
                if (req_s) begin
                    ack_d = 1'b1;
                end else if (timeout) begin
                    err_d = 1'b1;
                end
            end
            WAIT_REL: begin
                if (!req_s) begin
                    ack_d = 1'b0;
                end else if (timeout) begin
                    ack_d = 1'b0;
                    err_d = 1'b1;
                end
            end
            DELIVER: begin
                msg_d = shreg_q[MSG_MSB:MSG_LSB];
                // A reset packet only reports its type; the other fields keep the last game data.
                if (shreg_q[MSG_MSB:MSG_LSB] == MSG_RST) begin
                    rstp_d = 1'b1;
                end else begin
                    en_d   = 1'b1;
                    dir_d  = shreg_q[DIR_BIT];
                    bx_d   = shreg_q[BX_MSB:BX_LSB];
                    by_d   = shreg_q[BY_MSB:BY_LSB];
                    card_d = shreg_q[CARD_MSB:CARD_LSB];
                    sel_d  = shreg_q[SEL_MSB:SEL_LSB];
                end
            end
            default: begin
                ack_d = 1'b0;
            end
        endcase
    end

    assign Ack_out             = ack_q;
    assign interboard_en       = en_q;
    assign interboard_rst      = rstp_q;
    assign rx_error            = err_q;
    assign interboard_msg_type = msg_q;
    assign interboard_move_dir = dir_q;
    assign interboard_block_x  = bx_q;
    assign interboard_block_y  = by_q;
    assign interboard_card     = card_q;
    assign interboard_sel_len  = sel_q;

endmodule

// File: tb/tb_interboard_rx.sv
// Directed bench: instance a (timeout 64) for protocol tests, instance b (timeout 1000) for the long-hold case.
module tb_interboard_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req_a, req_b;
    logic [5:0] dat_a, dat_b;

    logic       ack_a, en_a, rp_a, err_a, dir_a;
    logic [3:0] msg_a;
    logic [4:0] bx_a;
    logic [2:0] by_a, sel_a;
    logic [5:0] card_a;

    logic       ack_b, en_b, rp_b, err_b, dir_b;
    logic [3:0] msg_b;
    logic [4:0] bx_b;
    logic [2:0] by_b, sel_b;
    logic [5:0] card_b;

    interboard_rx #(.TIMEOUT_CYCLES(64)) u_dut (
        .clk(clk), .rst(rst_n), .Request_in(req_a), .inter_data_in(dat_a),
        .Ack_out(ack_a), .interboard_en(en_a), .interboard_rst(rp_a),
        .interboard_msg_type(msg_a), .interboard_move_dir(dir_a),
        .interboard_block_x(bx_a), .interboard_block_y(by_a),
        .interboard_card(card_a), .interboard_sel_len(sel_a), .rx_error(err_a)
    );

    interboard_rx #(.TIMEOUT_CYCLES(1000)) u_dut_hold (
        .clk(clk), .rst(rst_n), .Request_in(req_b), .inter_data_in(dat_b),
        .Ack_out(ack_b), .interboard_en(en_b), .interboard_rst(rp_b),
        .interboard_msg_type(msg_b), .interboard_move_dir(dir_b),
        .interboard_block_x(bx_b), .interboard_block_y(by_b),
        .interboard_card(card_b), .interboard_sel_len(sel_b), .rx_error(err_b)
    );

    int checks = 0;
    int errors = 0;
    int ack_lat, ack_rises;
    int en_cnt, rp_cnt, both_cnt, pulse_at;
    logic [5:0] pulse_card;
    logic ack_at3, ack_at4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] mk_pkt(input logic [3:0] m, input logic d, input logic [4:0] x,
                                           input logic [2:0] y, input logic [5:0] c,
                                           input logic [2:0] s, input logic [1:0] pad);
        return {m, d, x, y, c, s, pad};
    endfunction

    function automatic logic [5:0] chunk_of(input logic [23:0] p, input int k);
        return p[23-6*k -: 6];
    endfunction

    task automatic send_chunk(input bit b, input logic [5:0] d, input int lat);
        @(posedge clk); #1;
        if (b) begin dat_b = d; req_b = 1'b1; end
        else   begin dat_a = d; req_a = 1'b1; end
        ack_lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if ((b ? ack_b : ack_a) === 1'b1) begin
                ack_lat = i;
                break;
            end
        end
        chk("ack_rise", b ? ack_b : ack_a, 1);
        ack_rises++;
        repeat (lat) @(posedge clk);
        #1;
        if (b) req_b = 1'b0;
        else   req_a = 1'b0;
    endtask

    task automatic wait_ack_low(input bit b);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if ((b ? ack_b : ack_a) === 1'b0) break;
        end
        chk("ack_fall", b ? ack_b : ack_a, 0);
    endtask

    task automatic watch(input bit b, input int n);
        en_cnt = 0; rp_cnt = 0; both_cnt = 0; pulse_at = 0; pulse_card = '0;
        ack_at3 = 1'bx; ack_at4 = 1'bx;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (i == 3) ack_at3 = b ? ack_b : ack_a;
            if (i == 4) ack_at4 = b ? ack_b : ack_a;
            if ((b ? en_b : en_a) === 1'b1) begin
                en_cnt++;
                if (pulse_at == 0) begin pulse_at = i; pulse_card = b ? card_b : card_a; end
            end
            if ((b ? rp_b : rp_a) === 1'b1) begin
                rp_cnt++;
                if (pulse_at == 0) pulse_at = i;
            end
            if ((b ? en_b : en_a) === 1'b1 && (b ? rp_b : rp_a) === 1'b1) both_cnt++;
        end
    endtask

    task automatic send_pkt(input bit b, input logic [23:0] p, input int lat);
        for (int k = 0; k < 4; k++) begin
            send_chunk(b, chunk_of(p, k), lat);
            if (k < 3) wait_ack_low(b);
        end
        watch(b, 6);
    endtask

    task automatic chk_fields_a(input string tag, input logic [3:0] m, input logic d, input logic [4:0] x,
                                input logic [2:0] y, input logic [5:0] c, input logic [2:0] s);
        chk({tag, "_msg"}, msg_a, m);
        chk({tag, "_dir"}, dir_a, d);
        chk({tag, "_bx"}, bx_a, x);
        chk({tag, "_by"}, by_a, y);
        chk({tag, "_card"}, card_a, c);
        chk({tag, "_sel"}, sel_a, s);
    endtask

    initial begin
        int low_cnt, errc, err_at, err_cnt;
        logic [23:0] p;

        rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; dat_a = '0; dat_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ack", ack_a, 0);
        chk("reset_pulses", {en_a, rp_a, err_a}, 0);
        chk("reset_fields", {msg_a, dir_a, bx_a, by_a, card_a, sel_a}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single packet: msg 3, dir 1, x 17, y 5, card 42, sel 2 -> 0x3C6D48
        ack_rises = 0;
        send_chunk(0, 6'b001111, 2);
        chk("t1_ack_latency", ack_lat, 4);
        wait_ack_low(0);
        send_chunk(0, 6'b000110, 2); wait_ack_low(0);
        send_chunk(0, 6'b110101, 2); wait_ack_low(0);
        send_chunk(0, 6'b001000, 2);
        watch(0, 6);
        chk("t1_ack_pulses", ack_rises, 4);
        chk("t1_ack_before_fall", ack_at3, 1);
        chk("t1_ack_fall_u3", ack_at4, 0);
        chk("t1_en_count", en_cnt, 1);
        chk("t1_en_at_u4", pulse_at, 5);
        chk("t1_rst_count", rp_cnt, 0);
        chk_fields_a("t1", 4'd3, 1'b1, 5'd17, 3'd5, 6'd42, 3'd2);
        repeat (10) @(negedge clk);
        chk("t1_hold_card", card_a, 42);
        chk("t1_hold_bx", bx_a, 17);

        // Reset packet keeps game fields, updates only the type
        send_pkt(0, mk_pkt(4'd15, 1'b0, 5'd3, 3'd2, 6'd9, 3'd5, 2'd0), 2);
        chk("t2_rst_count", rp_cnt, 1);
        chk("t2_en_count", en_cnt, 0);
        chk("t2_rst_at_u4", pulse_at, 5);
        chk_fields_a("t2", 4'd15, 1'b1, 5'd17, 3'd5, 6'd42, 3'd2);

        // Two chunks then silence: rx_error 64 cycles after the last transition
        p = mk_pkt(4'd1, 1'b1, 5'd1, 3'd1, 6'd1, 3'd1, 2'd0);
        send_chunk(0, chunk_of(p, 0), 2); wait_ack_low(0);
        send_chunk(0, chunk_of(p, 1), 2); wait_ack_low(0);
        err_at = 0; err_cnt = 0; en_cnt = 0;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (err_a === 1'b1) begin err_cnt++; if (err_at == 0) err_at = k; end
            if (en_a === 1'b1) en_cnt++;
        end
        chk("t3_err_at", err_at, 64);
        chk("t3_err_count", err_cnt, 1);
        chk("t3_no_en", en_cnt, 0);
        chk("t3_ack_low", ack_a, 0);
        chk("t3_card_kept", card_a, 42);
        send_pkt(0, mk_pkt(4'd5, 1'b0, 5'd31, 3'd7, 6'd0, 3'd7, 2'd3), 3);
        chk("t3_next_en", en_cnt, 1);
        chk_fields_a("t3", 4'd5, 1'b0, 5'd31, 3'd7, 6'd0, 3'd7);

        // Reset while chunk 2 is acknowledged
        p = mk_pkt(4'd9, 1'b1, 5'd9, 3'd3, 6'd33, 3'd4, 2'd0);
        send_chunk(0, chunk_of(p, 0), 2); wait_ack_low(0);
        send_chunk(0, chunk_of(p, 1), 2); wait_ack_low(0);
        @(posedge clk); #1 dat_a = chunk_of(p, 2); req_a = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (ack_a === 1'b1) break;
        end
        chk("t4_ack_before_rst", ack_a, 1);
        @(posedge clk); #1 rst_n = 1'b0; req_a = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t4_ack_zero", ack_a, 0);
        chk("t4_pulses_zero", {en_a, rp_a, err_a}, 0);
        chk("t4_fields_zero", {msg_a, dir_a, bx_a, by_a, card_a, sel_a}, 0);
        send_pkt(0, mk_pkt(4'd2, 1'b0, 5'd4, 3'd1, 6'd7, 3'd1, 2'd0), 2);
        chk("t4_en_count", en_cnt, 1);
        chk_fields_a("t4", 4'd2, 1'b0, 5'd4, 3'd1, 6'd7, 3'd1);

        // Back-to-back packets
        send_pkt(0, mk_pkt(4'd6, 1'b1, 5'd10, 3'd3, 6'd1, 3'd4, 2'd0), 1);
        chk("t5_first_en", en_cnt, 1);
        chk("t5_first_card", pulse_card, 1);
        chk("t5_never_both", both_cnt, 0);
        send_pkt(0, mk_pkt(4'd7, 1'b0, 5'd20, 3'd6, 6'd63, 3'd3, 2'd0), 1);
        chk("t5_second_en", en_cnt, 1);
        chk("t5_second_card", pulse_card, 63);
        chk_fields_a("t5", 4'd7, 1'b0, 5'd20, 3'd6, 6'd63, 3'd3);

        // Request held high 500 cycles on the long-timeout instance
        p = mk_pkt(4'd4, 1'b1, 5'd22, 3'd6, 6'd50, 3'd5, 2'd0);
        @(posedge clk); #1 dat_b = chunk_of(p, 0); req_b = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (ack_b === 1'b1) break;
        end
        chk("t6_ack_rise", ack_b, 1);
        low_cnt = 0; errc = 0;
        repeat (500) begin
            @(negedge clk);
            if (ack_b !== 1'b1) low_cnt++;
            if (err_b !== 1'b0) errc++;
        end
        chk("t6_ack_held", low_cnt, 0);
        chk("t6_no_error", errc, 0);
        @(posedge clk); #1 req_b = 1'b0;
        wait_ack_low(1);
        for (int k = 1; k < 4; k++) begin
            send_chunk(1, chunk_of(p, k), 2);
            if (k < 3) wait_ack_low(1);
        end
        watch(1, 6);
        chk("t6_en_count", en_cnt, 1);
        chk("t6_card", card_b, 50);
        chk("t6_bx", bx_b, 22);
        chk("t6_msg", msg_b, 4);
        chk("t6_sel", sel_b, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
